column_prefetch_buffer: RTL and testbench
=========================================

// Module: column_prefetch_buffer
// PURPOSE
//   Ping-pong column buffer between the texture ROM and the WS2812 strip controller.
//   On each new angle (theta) or animation frame, it prefetches all LED_COUNT pixels of one column from ROM into the idle bank.
//   Banks swap only on a strip-refresh boundary, so a strip refresh never shows pixels from two columns.
//   Replaces direct ROM addressing by the strip's pixel index.
// PARAMETERS
//   LED_COUNT   52     pixels per column (strip length)
//   TEX_WIDTH   64     columns per texture frame; theta range 0..TEX_WIDTH-1
//   NUM_FRAMES  30     animation frames stored in ROM
//   PIX_W       24     bits per pixel (GRB)
//   ROM_LAT     1      ROM read latency in clk cycles (addr -> data)
//   ADDR_W      17     ROM address width, = clog2(TEX_WIDTH*LED_COUNT*NUM_FRAMES)
// PORTS
//   clk         in   1       system clock, 100 MHz
//   reset_n     in   1       asynchronous active-low reset
//   theta       in   6       current angle column from the breakbeam angle generator
//   frame_idx   in   8       current animation frame index
//   frame_sync  in   1       1-cycle pulse: strip controller begins a new refresh (pixel index -> 0)
//   px_num      in   6       pixel index requested by the strip controller
//   pixel       out  PIX_W   colour for px_num, 1-cycle registered latency
//   rom_addr    out  ADDR_W  texture ROM address
//   rom_data    in   PIX_W   texture ROM data, valid ROM_LAT cycles after rom_addr
//   col_valid   out  1       high once the first column has been swapped in
//   fill_busy   out  1       high while in state FILL
//   overrun     out  8       saturating count of frame_sync pulses that arrived while in FILL
// BEHAVIOUR
//   Reset values: pixel=0, rom_addr=0, col_valid=0, fill_busy=0, overrun=0.
//     Internal state: disp_bank=0, state=IDLE, force_fill=1. Bank contents are not cleared.
//   Address: rom_addr = f*LED_COUNT*TEX_WIDTH + i*TEX_WIDTH + t, computed at ADDR_W width.
//     f and t are the latched request values; i is the fill counter 0..LED_COUNT-1.
//     If frame_idx >= NUM_FRAMES, f is 0.
//   FSM states:
//   - IDLE:
//       If force_fill, or theta != last_theta, or frame_idx != last_frame:
//       latch theta/frame_idx into req and last, clear force_fill, set i=0, go to FILL.
//   - FILL:
//       Issue one address per cycle for i=0..LED_COUNT-1.
//       Write rom_data into fill bank (!disp_bank) at index i delayed by ROM_LAT.
//       Go to READY after LED_COUNT+ROM_LAT cycles (53 by default).
//       If theta or frame_idx changes mid-fill: relatch and restart at i=0 on the next cycle.
//         Partial data is discarded; no swap occurs.
//   - READY:
//       On frame_sync: toggle disp_bank, set col_valid=1, go to IDLE.
//       If theta/frame changes before any frame_sync: relatch and return to FILL.
//         The stale column is never displayed.
//   - frame_sync together with a theta change in READY:
//       swap first (the completed column is shown), then IDLE refills on the next cycle.
//   - frame_sync in IDLE or FILL: no swap; disp_bank holds the previous column.
//       Only in FILL: overrun += 1, saturating at 255.
//   Read path: pixel <= (col_valid && px_num < LED_COUNT) ? disp_bank[px_num] : 0, every cycle.
//     The read port is independent of the fill write port; both are active in the same cycle.
//   reset_n asserted mid-fill: state returns to IDLE at once. col_valid drops, so output is blank.
//     After release, a full fill and one frame_sync are needed before col_valid=1.
//   theta wrap 63 -> 0 is an ordinary change; no special case.
// STRUCTURE
//   Shared package holo_pkg:
//     LED_COUNT, TEX_WIDTH, NUM_FRAMES, FRAME_SIZE=TEX_WIDTH*LED_COUNT, ADDR_W;
//     pixel_t (PIX_W vector); state enum {IDLE, FILL, READY}.
//   Sub-module column_bank_ram: LED_COUNT x PIX_W, 1 write / 1 registered read, two instances.
//     Alternatively one instance with a bank-select MSB on both ports.
//   Top level holds the FSM, fill counter, ROM_LAT-deep write-index/valid delay line, and swap logic.
// TESTING (ROM model: data = {frame[7:0], led[7:0], col[7:0]}, latency 1)
//   1. Reset release, theta=5, frame=0, frame_sync after 60 cycles:
//      -> fill_busy high for 53 cycles; then px_num=7 gives pixel=0x000705 one cycle later; col_valid=1.
//   2. theta 5->6 at fill cycle 20:
//      -> fill restarts at i=0; after the swap, every px returns col=0x06; no 0x05/0x06 mix in a bank.
//   3. frame_sync at fill cycle 10:
//      -> overrun=1; display still shows the previous column; swap on the next frame_sync after READY.
//   4. READY, with frame_sync and theta 9->10 in the same cycle:
//      -> col 9 displayed; FILL for col 10 starts the next cycle.
//   5. frame=29, theta=63, px_num=51 -> rom_addr=99839 issued; pixel=0x1D333F. px_num=55 -> pixel=0.
//   6. reset_n pulsed low mid-fill -> outputs are 0 within 1 cycle of assertion; recovery as in test 1.
//      Also: 300 frame_syncs during continuous theta changes -> overrun saturates at 255.

Source files
------------

// File: rtl/holo_pkg.sv
// Shared constants and types for the POV column prefetch path.
package holo_pkg;
  localparam int LED_COUNT  = 52;
  localparam int TEX_WIDTH  = 64;
  localparam int NUM_FRAMES = 30;
  localparam int PIX_W      = 24;
  localparam int ROM_LAT    = 1;
  localparam int FRAME_SIZE = TEX_WIDTH * LED_COUNT;
  localparam int ADDR_W     = $clog2(FRAME_SIZE * NUM_FRAMES);
  localparam int IDX_W      = $clog2(LED_COUNT);
  localparam int CNT_W      = $clog2(LED_COUNT + ROM_LAT + 1);

  typedef logic [PIX_W-1:0] pixel_t;
  typedef enum logic [1:0] {IDLE, FILL, READY} state_t;
endpackage

// File: rtl/column_bank_ram.sv
// One column bank: LED_COUNT pixels, one write port, one registered read port.
module column_bank_ram
  import holo_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  pixel_t           wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output pixel_t           rd_data
);
  pixel_t mem [LED_COUNT];

  // Fill-side write; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  // Display-side read, one cycle latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= mem[rd_idx];
  end
endmodule

// File: rtl/column_prefetch_buffer.sv
// Ping-pong column buffer: fills the idle bank from texture ROM, swaps on strip refresh.
module column_prefetch_buffer
  import holo_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [5:0]        theta,
  input  logic [7:0]        frame_idx,
  input  logic              frame_sync,
  input  logic [5:0]        px_num,
  output pixel_t            pixel,
  output logic [ADDR_W-1:0] rom_addr,
  input  pixel_t            rom_data,
  output logic              col_valid,
  output logic              fill_busy,
  output logic [7:0]        overrun
);
  localparam logic [CNT_W-1:0]  FILL_LAST  = CNT_W'(LED_COUNT + ROM_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_LC     = CNT_W'(LED_COUNT);
  localparam logic [CNT_W-1:0]  IDX_LAST   = CNT_W'(LED_COUNT - 1);
  localparam logic [5:0]        PX_LIM     = 6'(LED_COUNT);
  localparam logic [7:0]        FRM_LIM    = 8'(NUM_FRAMES);
  localparam logic [ADDR_W-1:0] FRAME_SZ_A = ADDR_W'(FRAME_SIZE);
  localparam logic [ADDR_W-1:0] TEX_W_A    = ADDR_W'(TEX_WIDTH);

  state_t             state_q, state_d;
  logic               latch, swap, changed, issue;
  logic               force_fill, disp_bank;
  logic [5:0]         last_theta;
  logic [7:0]         last_frame, req_f;
  logic [CNT_W-1:0]   cnt, fill_idx;
  logic [ROM_LAT-1:0]             vld_pipe;
  logic [ROM_LAT-1:0][IDX_W-1:0]  idx_pipe;
  logic [1:0]         bank_we;
  pixel_t [1:0]       rd_data;
  logic [IDX_W-1:0]   rd_idx;
  logic               blank_q, bank_q;

  assign changed   = force_fill || (theta != last_theta) || (frame_idx != last_frame);
  assign fill_busy = (state_q == FILL);
  // cnt runs past LED_COUNT-1 while waiting for ROM data; hold the address on the last pixel.
  assign fill_idx  = (cnt < CNT_LC) ? cnt : IDX_LAST;
  assign issue     = (state_q == FILL) && (cnt < CNT_LC);
  assign rom_addr  = ADDR_W'(req_f) * FRAME_SZ_A + ADDR_W'(fill_idx) * TEX_W_A
                   + ADDR_W'(last_theta);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: a request change always relatches, except that a swap in READY wins.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    swap    = 1'b0;
    case (state_q)
      IDLE:  if (changed) begin latch = 1'b1; state_d = FILL; end
      FILL:  if (changed) latch = 1'b1;
             else if (cnt == FILL_LAST) state_d = READY;
      READY: if (frame_sync) begin swap = 1'b1; state_d = IDLE; end
             else if (changed) begin latch = 1'b1; state_d = FILL; end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, fill counter, bank select, column-valid and overrun counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      force_fill <= 1'b1;
      last_theta <= '0;
      last_frame <= '0;
      req_f      <= '0;
      cnt        <= '0;
      disp_bank  <= 1'b0;
      col_valid  <= 1'b0;
      overrun    <= '0;
    end else begin
      if (latch) begin
        last_theta <= theta;
        last_frame <= frame_idx;
        req_f      <= (frame_idx < FRM_LIM) ? frame_idx : 8'd0;
        force_fill <= 1'b0;
        cnt        <= '0;
      end else if (state_q == FILL) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (swap) begin
        disp_bank <= ~disp_bank;
        col_valid <= 1'b1;
      end
      if ((state_q == FILL) && frame_sync && (overrun != 8'hFF))
        overrun <= overrun + 8'd1;
    end
  end

  // Write index/valid delay line matching the ROM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      idx_pipe[0] <= IDX_W'(fill_idx);
      for (int k = 1; k < ROM_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        idx_pipe[k] <= idx_pipe[k-1];
      end
    end
  end

  assign rd_idx = (px_num < PX_LIM) ? IDX_W'(px_num) : '0;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = vld_pipe[ROM_LAT-1] && (disp_bank == (b == 0));
    column_bank_ram u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (bank_we[b]),
      .wr_idx  (idx_pipe[ROM_LAT-1]),
      .wr_data (rom_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_data[b])
    );
  end

  // Blanking and bank select registered alongside the RAM read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= 1'b1;
      bank_q  <= 1'b0;
    end else begin
      blank_q <= !(col_valid && (px_num < PX_LIM));
      bank_q  <= disp_bank;
    end
  end

  assign pixel = blank_q ? '0 : rd_data[bank_q];
endmodule

// File: tb/tb_column_prefetch_buffer.sv
// Self-checking bench for column_prefetch_buffer with a column-level reference model.
module tb_column_prefetch_buffer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  theta = '0;
  logic [7:0]  frame_idx = '0;
  logic        frame_sync = 1'b0;
  logic [5:0]  px_num = '0;
  logic [23:0] pixel;
  logic [16:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic        col_valid, fill_busy;
  logic [7:0]  overrun;

  always #5 clk = ~clk;

  column_prefetch_buffer dut (
    .clk(clk), .reset_n(reset_n), .theta(theta), .frame_idx(frame_idx),
    .frame_sync(frame_sync), .px_num(px_num), .pixel(pixel), .rom_addr(rom_addr),
    .rom_data(rom_data), .col_valid(col_valid), .fill_busy(fill_busy), .overrun(overrun)
  );

  // Texture ROM: data = {frame, led, col}, one cycle latency.
  function automatic logic [23:0] rom_fn(input logic [16:0] a);
    int ai, f, led, col;
    ai  = int'(a);
    f   = ai / 3328;
    led = (ai % 3328) / 64;
    col = ai % 64;
    return {8'(f), 8'(led), 8'(col)};
  endfunction
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: which column is requested, being fetched, and shown.
  int          m_mode, m_left, m_ovr;   // mode 0 idle, 1 fetching, 2 complete
  bit          m_force, m_valid;
  logic [5:0]  m_lt, m_rt, m_dt;
  logic [7:0]  m_lf, m_rf, m_df;
  logic [23:0] m_pix;

  task automatic m_reset();
    m_mode = 0; m_left = 0; m_ovr = 0; m_force = 1; m_valid = 0;
    m_lt = 0; m_rt = 0; m_dt = 0; m_lf = 0; m_rf = 0; m_df = 0; m_pix = 0;
  endtask

  task automatic m_latch();
    m_lt = theta; m_lf = frame_idx; m_rt = theta;
    m_rf = (int'(frame_idx) < 30) ? frame_idx : 8'd0;
    m_force = 0; m_mode = 1; m_left = 53;
  endtask

  task automatic m_update();
    bit chg;
    chg = m_force || (theta != m_lt) || (frame_idx != m_lf);
    case (m_mode)
      0: if (chg) m_latch();
      1: begin
        if (frame_sync && m_ovr < 255) m_ovr++;
        if (chg) m_latch();
        else begin
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
      end
      default: begin
        if (frame_sync) begin
          m_dt = m_rt; m_df = m_rf; m_valid = 1; m_mode = 0;
        end else if (chg) m_latch();
      end
    endcase
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    logic [23:0] ep;
    int i;
    ep = (m_valid && int'(px_num) < 52) ? {m_df, 2'b00, px_num, 2'b00, m_dt} : 24'h0;
    if (!reset_n) begin m_reset(); ep = 0; end
    else m_update();
    @(posedge clk);
    @(negedge clk);
    m_pix = ep;
    chk("pixel", int'(pixel), int'(m_pix));
    chk("fill_busy", int'(fill_busy), (m_mode == 1) ? 1 : 0);
    chk("col_valid", int'(col_valid), int'(m_valid));
    chk("overrun", int'(overrun), m_ovr);
    i = 53 - m_left;
    if (m_mode == 1 && i < 52)
      chk("rom_addr", int'(rom_addr), int'(m_rf) * 3328 + i * 64 + int'(m_rt));
  endtask

  typedef struct {
    logic [5:0]  t;
    logic [7:0]  f;
    logic [5:0]  px;
    logic [23:0] pix;
    bit          ca;
    int          addr;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int busy;
    vecs[0] = '{6'd63, 8'd29, 6'd51, 24'h1D333F, 1'b1, 96575};
    vecs[1] = '{6'd63, 8'd29, 6'd55, 24'h000000, 1'b0, 0};
    vecs[2] = '{6'd0,  8'd29, 6'd3,  24'h1D0300, 1'b1, 96512};
    vecs[3] = '{6'd10, 8'd40, 6'd0,  24'h00000A, 1'b1, 10};
    vecs[4] = '{6'd0,  8'd2,  6'd51, 24'h023300, 1'b1, 6656};

    // Reset state
    m_reset();
    theta = 6'd5; frame_idx = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_pixel", int'(pixel), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_col_valid", int'(col_valid), 0);
    chk("rst_fill_busy", int'(fill_busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset_n = 1'b1;

    // First fill after reset and first swap
    busy = 0;
    for (int c = 0; c < 60; c++) begin step(); busy += int'(fill_busy); end
    chk("t1_fill_len", busy, 53);
    chk("t1_valid_pre", int'(col_valid), 0);
    frame_sync = 1'b1; step(); frame_sync = 1'b0;
    px_num = 6'd7; step();
    chk("t1_px7", int'(pixel), 'h000705);
    chk("t1_valid", int'(col_valid), 1);

    // Request change at fill cycle 20: restart, whole bank from the new column
    frame_idx = 8'd1; step();
    repeat (19) step();
    theta = 6'd6;
    for (int c = 0; c < 70; c++) begin px_num = 6'($urandom_range(0, 63)); step(); end
    frame_sync = 1'b1; step(); frame_sync = 1'b0;
    for (int i = 0; i < 52; i++) begin
      px_num = 6'(i); step();
      chk("t2_col6", int'(pixel), 'h010006 | (i << 8));
    end

    // frame_sync during fill: counted, no swap
    theta = 6'd9; step();
    repeat (9) step();
    frame_sync = 1'b1; step(); frame_sync = 1'b0;
    chk("t3_overrun", int'(overrun), 1);
    px_num = 6'd3; step();
    chk("t3_old_col", int'(pixel), 'h010306);
    repeat (60) step();
    chk("t3_ready", int'(fill_busy), 0);
    step();
    chk("t3_no_swap", int'(pixel), 'h010306);

    // READY: frame_sync and theta change together
    frame_sync = 1'b1; theta = 6'd10; step(); frame_sync = 1'b0;
    chk("t4_idle", int'(fill_busy), 0);
    px_num = 6'd4; step();
    chk("t4_refill", int'(fill_busy), 1);
    chk("t4_col9", int'(pixel), 'h010409);
    repeat (60) step();
    frame_sync = 1'b1; step(); frame_sync = 1'b0;

    // Table: address mapping, frame clamp, wrap, out-of-range pixel
    for (int v = 0; v < 5; v++) begin
      theta = vecs[v].t; frame_idx = vecs[v].f;
      step();
      if (vecs[v].ca) chk("vec_addr", int'(rom_addr), vecs[v].addr);
      for (int c = 0; c < 58; c++) begin px_num = 6'($urandom_range(0, 63)); step(); end
      frame_sync = 1'b1; step(); frame_sync = 1'b0;
      px_num = vecs[v].px; step();
      chk("vec_pixel", int'(pixel), int'(vecs[v].pix));
    end

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) == 0)  theta = 6'($urandom);
      if ($urandom_range(0, 299) == 0) frame_idx = 8'($urandom_range(0, 35));
      frame_sync = ($urandom_range(0, 29) == 0);
      px_num = 6'($urandom_range(0, 63));
      step();
    end
    frame_sync = 1'b0;

    // Reset mid-fill, then recovery
    theta = theta + 6'd1; step();
    repeat (14) step();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_pixel", int'(pixel), 0);
    chk("t6_col_valid", int'(col_valid), 0);
    chk("t6_fill_busy", int'(fill_busy), 0);
    chk("t6_overrun", int'(overrun), 0);
    m_reset();
    step(); step();
    reset_n = 1'b1;
    theta = 6'd20; frame_idx = 8'd0;
    busy = 0;
    for (int c = 0; c < 60; c++) begin step(); busy += int'(fill_busy); end
    chk("t6_fill_len", busy, 53);
    frame_sync = 1'b1; step(); frame_sync = 1'b0;
    px_num = 6'd7; step();
    chk("t6_px7", int'(pixel), 'h000714);

    // Overrun saturation under continuous theta changes
    for (int c = 0; c < 300; c++) begin
      theta = theta + 6'd1; frame_sync = 1'b1; step();
    end
    frame_sync = 1'b0;
    chk("t6_overrun_sat", int'(overrun), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
